// File: rtl/toggle_rx_pkg.sv
// Shared types and default parameters for the two-phase toggle receiver.
package toggle_rx_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    IDLE  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the async input one stage deeper per clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // synchronizer flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Two-phase (toggle) handshake receiver: captures one payload per req_tgl
// level change, presents it valid/ready, and returns a toggle acknowledge.
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_tgl,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err,
  input  logic             err_clr
);

  localparam int unsigned          ACNT_W     = 3;
  localparam logic [ACNT_W-1:0]    ALIGN_LAST = ACNT_W'(SYNC_STAGES);

  logic              req_s;
  logic              event_s;
  logic              err_set_s;
  state_e            state_q,     state_d;
  logic [ACNT_W-1:0] align_cnt_q, align_cnt_d;
  logic              last_seen_q, last_seen_d;
  logic              ack_q,       ack_d;
  logic              valid_q,     valid_d;
  logic [WIDTH-1:0]  data_q,      data_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              err_q,       err_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_tgl),
    .q     (req_s)
  );

  assign event_s = (req_s != last_seen_q);

  // next-state and output logic for the handshake FSM
  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    last_seen_d = last_seen_q;
    ack_d       = ack_q;
    valid_d     = valid_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_set_s   = 1'b0;
    case (state_q)
      ALIGN: begin
        // events are ignored until the synchronizer holds a settled sender level
        if (align_cnt_q == ALIGN_LAST) begin
          last_seen_d = req_s;
          ack_d       = req_s;
          state_d     = IDLE;
        end else begin
          align_cnt_d = align_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (event_s) begin
          data_d      = data_in;
          valid_d     = 1'b1;
          last_seen_d = req_s;
          state_d     = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
        // sender toggled again before our ack: consume the edge, drop its payload
        if (event_s) begin
          err_set_s   = 1'b1;
          last_seen_d = req_s;
        end else begin
          err_set_s = 1'b0;
        end
      end
      default: begin
        state_d     = ALIGN;
        align_cnt_d = '0;
      end
    endcase

    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ALIGN;
      align_cnt_q <= '0;
      last_seen_q <= 1'b0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      last_seen_q <= last_seen_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign ack_tgl   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_toggle_rx.sv
// Self-checking bench for toggle_rx: directed handshake cases plus randomized
// transfers scored against a transaction-level sender/consumer model.
module tb_toggle_rx;

  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int CW    = 4;

  logic             clk;
  logic             rst_n;
  logic             req_tgl;
  logic [WIDTH-1:0] data_in;
  logic             ack_tgl;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    xfer_cnt;
  logic             proto_err;
  logic             err_clr;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;
  bit exp_ack  = 1'b0;

  toggle_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_tgl   (req_tgl),
    .data_in   (data_in),
    .ack_tgl   (ack_tgl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  // Apply reset mid-cycle with the sender parked at lvl, then check alignment.
  task automatic do_reset(input logic lvl);
    #2;
    rst_n     = 1'b0;
    req_tgl   = lvl;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ack",   {31'd0, ack_tgl},   32'd0);
    chk("rst_cnt",   {28'd0, xfer_cnt},  32'd0);
    chk("rst_err",   {31'd0, proto_err}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("align_mask_ack", {31'd0, ack_tgl}, 32'd0);
    @(negedge clk);
    chk("align_ack",   {31'd0, ack_tgl},   {31'd0, lvl});
    chk("align_valid", {31'd0, out_valid}, 32'd0);
    chk("align_cnt",   {28'd0, xfer_cnt},  32'd0);
    exp_ack = lvl;
    exp_cnt = 0;
  endtask

  // One well-behaved transfer; consumer stalls for 'delay' cycles after valid.
  task automatic xfer(input logic [WIDTH-1:0] d, input int delay);
    data_in   = d;
    out_ready = (delay == 0);
    req_tgl   = ~req_tgl;
    wait_valid(SS + 4);
    chk("xf_data", {24'd0, out_data}, {24'd0, d});
    chk("xf_ack_hold", {31'd0, ack_tgl}, {31'd0, exp_ack});
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("xf_stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_ack = ~exp_ack;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("xf_ack",   {31'd0, ack_tgl},   {31'd0, exp_ack});
    chk("xf_cnt",   {28'd0, xfer_cnt},  exp_cnt);
    chk("xf_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_tgl = 1'b1; data_in = '0; out_ready = 1'b0; err_clr = 1'b0;

    // reset release with sender at level 1
    @(negedge clk);
    do_reset(1'b1);

    // from req=ack=0: exact latency of capture and ack
    do_reset(1'b0);
    out_ready = 1'b1;
    data_in   = 8'hA5;
    req_tgl   = 1'b1;
    @(negedge clk); chk("lat_e1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_e2_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_e3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_e3_data", {24'd0, out_data}, 32'h0000_00A5);
    chk("lat_e3_ack",  {31'd0, ack_tgl},  32'd0);
    @(negedge clk); chk("lat_e4_ack", {31'd0, ack_tgl}, 32'd1);
    chk("lat_e4_cnt",   {28'd0, xfer_cnt},  32'd1);
    chk("lat_e4_valid", {31'd0, out_valid}, 32'd0);
    exp_ack = 1'b1; exp_cnt = 1;
    out_ready = 1'b0;

    // consumer backpressure for 10 cycles
    xfer(8'h3C, 10);

    // second toggle while holding -> protocol error, payload dropped, one ack
    data_in = 8'h11; req_tgl = ~req_tgl;
    wait_valid(SS + 4);
    data_in = 8'h22; req_tgl = ~req_tgl;
    repeat (SS + 2) @(negedge clk);
    chk("viol_err",  {31'd0, proto_err}, 32'd1);
    chk("viol_data", {24'd0, out_data},  32'h0000_0011);
    chk("viol_ack",  {31'd0, ack_tgl},   {31'd0, exp_ack});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ack = ~exp_ack; exp_cnt = (exp_cnt + 1) % (1 << CW);
    repeat (6) @(negedge clk);
    chk("viol_one_ack", {31'd0, ack_tgl},   {31'd0, exp_ack});
    chk("viol_cnt",     {28'd0, xfer_cnt},  exp_cnt);
    chk("viol_dropped", {31'd0, out_valid}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, proto_err}, 32'd0);

    // clear coinciding with a fresh violation: the violation wins
    data_in = 8'h33; req_tgl = ~req_tgl;
    wait_valid(SS + 4);
    data_in = 8'h44; req_tgl = ~req_tgl;
    repeat (SS) @(negedge clk);
    chk("pre_viol_err", {31'd0, proto_err}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    chk("clr_vs_set", {31'd0, proto_err}, 32'd1);
    @(negedge clk);
    chk("clr_after", {31'd0, proto_err}, 32'd0);
    err_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ack = ~exp_ack; exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("clr_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
    chk("clr_data", {24'd0, out_data}, 32'h0000_0033);

    // 17 back-to-back transfers wrap the 4-bit counter to 1
    @(negedge clk);
    do_reset(req_tgl);
    for (int i = 0; i < 17; i++) xfer(8'(i * 7 + 1), 0);
    chk("wrap_cnt", {28'd0, xfer_cnt},  32'd1);
    chk("wrap_err", {31'd0, proto_err}, 32'd0);

    // randomized well-behaved traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(8'($urandom), int'($urandom_range(0, 5)));
    end
    chk("rand_err", {31'd0, proto_err}, 32'd0);

    // reset while holding a payload: discarded, no spurious transfer afterwards
    data_in = 8'h5A; req_tgl = ~req_tgl;
    wait_valid(SS + 4);
    chk("hold_before_rst", {24'd0, out_data}, 32'h0000_005A);
    do_reset(req_tgl);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_ack",   {31'd0, ack_tgl},   {31'd0, exp_ack});
    end
    xfer(8'hC3, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
